sng_stream: RTL and testbench
=============================

SNG_STREAM -- requirements
Module: sng_stream

Interface
REQ-001 Parameter BITSTREAM, default 64: stream length N; SHALL be a power of two >= 4.
REQ-002 Parameter BASE, default 61: Weyl start value, 0..N-1.
REQ-003 Parameter STRIDE, default 17: Weyl increment; SHALL be odd, so it is coprime with N.
REQ-004 Parameter QUANT, default 8: input data width per channel.
REQ-005 Parameter NCH, default 4: channel count, 1..32.
REQ-006 Parameter CH_OFFSET, default 0: per-channel Weyl start offset; channel c starts at (BASE + c*CH_OFFSET) mod N.
REQ-007 iClk  in  1  clock; all state SHALL update on its rising edge.
REQ-008 iRst  in  1  reset; asynchronous, active-high.
REQ-009 iValid  in  1  input word valid.
REQ-010 oReady  out  1  block accepts an input word.
REQ-011 iData  in  NCH*QUANT  channel c is in bits [c*QUANT +: QUANT].
REQ-012 oValid  out  1  oBits valid.
REQ-013 iReady  in  1  downstream accepts oBits.
REQ-014 oBits  out  NCH  current stochastic bit, one per channel.
REQ-015 oLast  out  1  marks bit index N-1 of the stream.

Function
REQ-016 The block SHALL have two FSM states: IDLE and RUN.
REQ-017 An input transfer SHALL occur when iValid && oReady.
REQ-018 On a transfer, the block SHALL latch quota[c] = (iData_c*N + 2^(QUANT-1)) >> QUANT per channel, with width clog2(N)+1 and range 0..N.
REQ-019 On a transfer, the block SHALL set bit index t=0, load w[c] with its start value, and enter RUN.
REQ-020 In RUN, outputs SHALL be oValid=1, oBits[c] = (w[c] < quota[c]), and oLast = (t == N-1).
REQ-021 In RUN, an output transfer SHALL occur when oValid && iReady; on it, t increments and w[c] = (w[c] + STRIDE) mod N, with the modulo done by truncation to clog2(N) bits.
REQ-022 While iReady=0, oBits, oLast, t and w SHALL hold unchanged.
REQ-023 oReady SHALL be 1 in IDLE, and 1 in RUN only when oLast && iReady; it SHALL be 0 otherwise.
REQ-024 On the final output transfer: with an input transfer in the same cycle, the block SHALL restart RUN at t=0 with the new quota (no bubble); without one, it SHALL go to IDLE.
REQ-025 Each stream SHALL contain exactly quota[c] ones, so quota 0 gives all zeros and quota N gives all ones.
REQ-026 In IDLE, oValid, oBits and oLast SHALL be 0.
REQ-027 Latency SHALL be one cycle: the first bit is presented in the cycle after the input transfer.

Reset
REQ-028 Asserting iRst SHALL immediately set state to IDLE and set t, w, quota, oValid, oBits and oLast to 0, including mid-stream; any partial stream SHALL be discarded.
REQ-029 After deassertion of iRst, oReady SHALL be 1.

Configuration
REQ-030 Macro SNG_STREAM_BIPOLAR_EN SHALL select the input encoding.
REQ-031 With SNG_STREAM_BIPOLAR_EN defined, iData_c SHALL be two's complement over [-1,1), and the quota SHALL be computed from iData_c with its MSB inverted, so -2^(QUANT-1) maps to quota 0 and 0 maps to quota N/2.
REQ-032 With SNG_STREAM_BIPOLAR_EN undefined, iData_c SHALL be unsigned unipolar, and no inversion logic SHALL exist.

Structure
REQ-033 Package sng_pkg SHALL hold the state enum (IDLE, RUN) and a quota function parameterised by N and QUANT.
REQ-034 Sub-module sng_weyl_lane SHALL implement one channel: start-value load, STRIDE accumulate under enable, and the comparator against quota; sng_stream SHALL instantiate it NCH times.

Verification (N=64, QUANT=8, BASE=61, STRIDE=17, CH_OFFSET=0)
REQ-035 iData_c=128, iReady=1 -> quota 32; the bench SHALL see bit0=0 (w=61), bit1=1 (w=14), exactly 32 ones in 64 cycles, and oLast only on cycle 64.
REQ-036 iData_c=0 -> 64 zeros; iData_c=255 -> quota 64 -> 64 ones.
REQ-037 iReady low for 3 cycles at t=5 -> oBits and oLast held for those 3 cycles; the stream resumes at t=5 and the total stays 64 bits.
REQ-038 iValid held high with two words -> second stream starts in the cycle after the first stream's oLast transfer, with no idle cycle between streams.
REQ-039 iRst asserted at t=20 -> oValid=0 in the same cycle; after release, the next stream starts from w=61.
REQ-040 Bipolar build, iData_c=8'h80 -> all zeros; iData_c=8'h00 -> exactly 32 ones.

Source files
------------

// File: rtl/sng_pkg.sv
// Shared types and helpers for the stochastic number generator stream.
// Holds the FSM state enum and the input-to-quota conversion.
package sng_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sngState_e;

  // Round-to-nearest scaling of a QUANT-bit code onto 0..n ones per stream.
  // Result is wide; callers truncate to clog2(n)+1 bits. Valid for QUANT <= 24.
  function automatic logic [63:0] calcQuota(input logic [31:0]   data,
                                            input int unsigned   n,
                                            input int unsigned   quant);
    logic [63:0] acc;
    acc = 64'(data) * 64'(n) + (64'(1) << (quant - 1));
    return acc >> quant;
  endfunction

endpackage

// File: rtl/sng_weyl_lane.sv
// One SNG channel: Weyl sequence w advancing by STRIDE mod BITSTREAM,
// compared against a latched quota to produce one stochastic bit per step.
// Ports:
//   iClk, iRst  clock, async active-high reset
//   iLoad       load start value and new quota (first bit of a stream)
//   iAdvance    step w by STRIDE (output transfer mid-stream)
//   iClear      force the bit low (stream finished, block going idle)
//   iQuota      quota for the stream being loaded, 0..BITSTREAM
//   oBit        registered stochastic bit, (w < quota)
module sng_weyl_lane #(
  parameter int unsigned BITSTREAM = 64,
  parameter int unsigned STRIDE    = 17,
  parameter int unsigned START     = 0
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic                         iLoad,
  input  logic                         iAdvance,
  input  logic                         iClear,
  input  logic [$clog2(BITSTREAM):0]   iQuota,
  output logic                         oBit
);

  localparam int unsigned WW = $clog2(BITSTREAM);
  localparam int unsigned QW = WW + 1;

  logic [WW-1:0] w;
  logic [QW-1:0] quota;
  logic [WW-1:0] wNext;
  logic [WW-1:0] wStart;

  // Modulo BITSTREAM is free: it is a power of two, so truncation wraps.
  assign wNext  = w + WW'(STRIDE);
  assign wStart = WW'(START);

  // Weyl state, quota latch and registered comparator output.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      w     <= '0;
      quota <= '0;
      oBit  <= 1'b0;
    end else if (iLoad) begin
      w     <= wStart;
      quota <= iQuota;
      oBit  <= ({1'b0, wStart} < iQuota);
    end else if (iAdvance) begin
      w     <= wNext;
      oBit  <= ({1'b0, wNext} < quota);
    end else if (iClear) begin
      oBit  <= 1'b0;
    end
  end

endmodule

// File: rtl/sng_stream.sv
// Stochastic number generator: each accepted input word becomes a stream of
// BITSTREAM bits per channel whose ones-count equals the channel's quota.
// Build option: define SNG_STREAM_BIPOLAR_EN for two's complement input
// over [-1,1); otherwise inputs are unsigned unipolar.
// Ports:
//   iClk, iRst  clock, async active-high reset
//   iValid/oReady/iData   input word handshake, channel c at [c*QUANT +: QUANT]
//   oValid/iReady         output bit handshake
//   oBits                 one stochastic bit per channel
//   oLast                 marks the final bit (index BITSTREAM-1) of a stream
module sng_stream
  import sng_pkg::*;
#(
  parameter int unsigned BITSTREAM = 64,
  parameter int unsigned BASE      = 61,
  parameter int unsigned STRIDE    = 17,
  parameter int unsigned QUANT     = 8,
  parameter int unsigned NCH       = 4,
  parameter int unsigned CH_OFFSET = 0
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic [NCH*QUANT-1:0]    iData,
  output logic                    oValid,
  input  logic                    iReady,
  output logic [NCH-1:0]          oBits,
  output logic                    oLast
);

  localparam int unsigned WW = $clog2(BITSTREAM);
  localparam int unsigned QW = WW + 1;

  sngState_e     state;
  sngState_e     stateNext;
  logic [WW-1:0] t;
  logic          inXfer;
  logic          outXfer;
  logic          load;
  logic          advance;
  logic          clear;

  // oValid is the state register itself; oReady must see iReady the same
  // cycle so a new word can be taken on the final bit without a bubble.
  assign oValid  = (state == RUN);
  assign oReady  = (state == IDLE) || (oLast && iReady);
  assign inXfer  = iValid && oReady;
  assign outXfer = oValid && iReady;

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and lane controls.
  always_comb begin
    stateNext = state;
    load      = 1'b0;
    advance   = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (inXfer) begin
          load      = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        if (outXfer) begin
          if (oLast) begin
            if (inXfer) begin
              load = 1'b1;
            end else begin
              clear     = 1'b1;
              stateNext = IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Bit index and last flag; oLast is registered by looking one step ahead.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      t     <= '0;
      oLast <= 1'b0;
    end else if (load || clear) begin
      t     <= '0;
      oLast <= 1'b0;
    end else if (advance) begin
      t     <= t + WW'(1);
      oLast <= (t == WW'(BITSTREAM - 2));
    end
  end

  for (genvar c = 0; c < int'(NCH); c++) begin : gLane
    localparam int unsigned START = (BASE + c * CH_OFFSET) % BITSTREAM;

    logic [QUANT-1:0] dRaw;
    logic [QUANT-1:0] dCode;
    logic [QW-1:0]    quota;

    assign dRaw = iData[c*QUANT +: QUANT];

`ifdef SNG_STREAM_BIPOLAR_EN
    // Flipping the sign bit turns two's complement into offset binary.
    assign dCode = dRaw ^ (QUANT'(1) << (QUANT - 1));
`else
    assign dCode = dRaw;
`endif

    assign quota = QW'(calcQuota(32'(dCode), BITSTREAM, QUANT));

    sng_weyl_lane #(
      .BITSTREAM (BITSTREAM),
      .STRIDE    (STRIDE),
      .START     (START)
    ) uLane (
      .iClk     (iClk),
      .iRst     (iRst),
      .iLoad    (load),
      .iAdvance (advance),
      .iClear   (clear),
      .iQuota   (quota),
      .oBit     (oBits[c])
    );
  end

endmodule

// File: tb/tb_sng_stream.sv
// Scoreboard bench for sng_stream at N=64, QUANT=8, BASE=61, STRIDE=17, NCH=4.
module tb_sng_stream;

  localparam int unsigned N      = 64;
  localparam int unsigned QUANT  = 8;
  localparam int unsigned NCH    = 4;
  localparam int unsigned BASE   = 61;
  localparam int unsigned STRIDE = 17;

`ifdef SNG_STREAM_BIPOLAR_EN
  localparam logic [7:0] D_HALF = 8'h00;
  localparam logic [7:0] D_ZERO = 8'h80;
  localparam logic [7:0] D_FULL = 8'h7F;
  localparam logic [7:0] D_QTR  = 8'h40;
  localparam int         ONES_QTR = 48;
`else
  localparam logic [7:0] D_HALF = 8'd128;
  localparam logic [7:0] D_ZERO = 8'd0;
  localparam logic [7:0] D_FULL = 8'd255;
  localparam logic [7:0] D_QTR  = 8'd64;
  localparam int         ONES_QTR = 16;
`endif

  typedef struct packed {
    logic [NCH-1:0] bits;
    logic           last;
  } exp_t;

  logic                 iClk = 1'b0;
  logic                 iRst;
  logic                 iValid;
  logic                 oReady;
  logic [NCH*QUANT-1:0] iData;
  logic                 oValid;
  logic                 iReady;
  logic [NCH-1:0]       oBits;
  logic                 oLast;

  exp_t sb[$];
  exp_t cur;
  int   nChecks = 0;
  int   nPass   = 0;
  int   streamPos = 0;
  int   streamsDone = 0;
  int   lastLen = 0;
  int   onesCnt[NCH];
  int   lastOnes[NCH];
  logic firstBits[2];
  logic prevInXfer = 1'b0;

  always #5 iClk = ~iClk;

  sng_stream #(
    .BITSTREAM (N),
    .BASE      (BASE),
    .STRIDE    (STRIDE),
    .QUANT     (QUANT),
    .NCH       (NCH),
    .CH_OFFSET (0)
  ) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iValid (iValid),
    .oReady (oReady),
    .iData  (iData),
    .oValid (oValid),
    .iReady (iReady),
    .oBits  (oBits),
    .oLast  (oLast)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
  endtask

  function automatic int modelQuota(input logic [QUANT-1:0] d);
    logic [QUANT-1:0] m;
    m = d;
`ifdef SNG_STREAM_BIPOLAR_EN
    m = d ^ 8'h80;
`endif
    return (int'(m) * int'(N) + 128) >> QUANT;
  endfunction

  function automatic void pushStream(input logic [NCH*QUANT-1:0] d);
    int   q[NCH];
    int   w;
    exp_t e;
    for (int c = 0; c < int'(NCH); c++) q[c] = modelQuota(d[c*QUANT +: QUANT]);
    for (int k = 0; k < int'(N); k++) begin
      w = (int'(BASE) + k * int'(STRIDE)) % int'(N);
      for (int c = 0; c < int'(NCH); c++) e.bits[c] = (w < q[c]);
      e.last = (k == int'(N) - 1);
      sb.push_back(e);
    end
  endfunction

  // Output monitor: compares presented bits against the scoreboard head,
  // pops on transfer, and queues a new stream on each input transfer.
  always @(negedge iClk) begin
    if (iRst) begin
      prevInXfer = 1'b0;
      streamPos  = 0;
      for (int c = 0; c < int'(NCH); c++) onesCnt[c] = 0;
    end else begin
      check("valid_vs_pending", 32'(oValid), 32'(sb.size() != 0));
      if (prevInXfer) check("latency_or_bubble", 32'(oValid), 32'd1);
      check("ready", 32'(oReady), 32'(!oValid || (oLast && iReady)));
      if (!oValid) begin
        check("idle_bits", 32'(oBits), 32'd0);
        check("idle_last", 32'(oLast), 32'd0);
      end else if (sb.size() != 0) begin
        cur = sb[0];
        check("bits", 32'(oBits), 32'(cur.bits));
        check("last", 32'(oLast), 32'(cur.last));
        if (iReady) begin
          void'(sb.pop_front());
          for (int c = 0; c < int'(NCH); c++) onesCnt[c] += int'(oBits[c]);
          if (streamPos < 2) firstBits[streamPos] = oBits[0];
          streamPos++;
          if (cur.last) begin
            for (int c = 0; c < int'(NCH); c++) begin
              lastOnes[c] = onesCnt[c];
              onesCnt[c]  = 0;
            end
            lastLen   = streamPos;
            streamPos = 0;
            streamsDone++;
          end
        end
      end
      prevInXfer = iValid && oReady;
      if (prevInXfer) pushStream(iData);
    end
  end

  task automatic sendWord(input logic [NCH*QUANT-1:0] d, input bit keepValid);
    bit acc;
    int budget;
    acc    = 1'b0;
    budget = 0;
    iValid = 1'b1;
    iData  = d;
    while (!acc && budget < 400) begin
      @(negedge iClk);
      acc = oReady;
      @(posedge iClk);
      #1;
      budget++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    if (!keepValid) iValid = 1'b0;
  endtask

  task automatic waitIdle();
    int budget;
    budget = 0;
    while ((sb.size() != 0 || oValid) && budget < 600) begin
      @(posedge iClk);
      #1;
      budget++;
    end
    if (budget >= 600) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitPos(input int pos);
    int budget;
    budget = 0;
    while (streamPos != pos && budget < 200) begin
      @(posedge iClk);
      #1;
      budget++;
    end
    if (budget >= 200) check("pos_timeout", 32'd0, 32'd1);
  endtask

  task automatic checkOnes(input string tag, input int e0, input int e1, input int e2, input int e3);
    check({tag, "_len"}, 32'(lastLen), 32'(N));
    check({tag, "_ones0"}, 32'(lastOnes[0]), 32'(e0));
    check({tag, "_ones1"}, 32'(lastOnes[1]), 32'(e1));
    check({tag, "_ones2"}, 32'(lastOnes[2]), 32'(e2));
    check({tag, "_ones3"}, 32'(lastOnes[3]), 32'(e3));
  endtask

  function automatic logic [NCH*QUANT-1:0] rep(input logic [7:0] d);
    return {NCH{d}};
  endfunction

  initial begin
    int doneBefore;
    logic [NCH*QUANT-1:0] rd;
    iRst   = 1'b1;
    iValid = 1'b0;
    iReady = 1'b1;
    iData  = '0;
    #1;
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_bits",  32'(oBits),  32'd0);
    check("rst_last",  32'(oLast),  32'd0);
    repeat (2) @(posedge iClk);
    #1;
    iRst = 1'b0;
    #1;
    check("rst_ready", 32'(oReady), 32'd1);

    // Half-scale: first bit from w=61 is 0, second from w=14 is 1.
    sendWord(rep(D_HALF), 1'b0);
    waitIdle();
    checkOnes("half", 32, 32, 32, 32);
    check("half_bit0", 32'(firstBits[0]), 32'd0);
    check("half_bit1", 32'(firstBits[1]), 32'd1);

    sendWord(rep(D_ZERO), 1'b0);
    waitIdle();
    checkOnes("zero", 0, 0, 0, 0);

    sendWord(rep(D_FULL), 1'b0);
    waitIdle();
    checkOnes("full", 64, 64, 64, 64);

    sendWord({D_QTR, D_HALF, D_ZERO, D_FULL}, 1'b0);
    waitIdle();
    checkOnes("mixed", 64, 0, 32, ONES_QTR);

    // Stall three cycles at t=5; the monitor checks the held bit each cycle.
    sendWord(rep(D_HALF), 1'b0);
    waitPos(5);
    iReady = 1'b0;
    repeat (3) begin
      @(posedge iClk);
      #1;
    end
    check("stall_pos", 32'(streamPos), 32'd5);
    iReady = 1'b1;
    waitIdle();
    checkOnes("stall", 32, 32, 32, 32);

    // Back-to-back words with iValid held high.
    doneBefore = streamsDone;
    sendWord(rep(D_FULL), 1'b1);
    sendWord(rep(D_ZERO), 1'b0);
    waitIdle();
    check("b2b_streams", 32'(streamsDone - doneBefore), 32'd2);
    checkOnes("b2b", 0, 0, 0, 0);

    // Reset mid-stream at t=20.
    sendWord(rep(D_HALF), 1'b0);
    waitPos(20);
    iRst = 1'b1;
    #1;
    check("midrst_valid", 32'(oValid), 32'd0);
    check("midrst_bits",  32'(oBits),  32'd0);
    check("midrst_last",  32'(oLast),  32'd0);
    sb.delete();
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    #1;
    check("midrst_ready", 32'(oReady), 32'd1);
    sendWord(rep(D_HALF), 1'b0);
    waitIdle();
    checkOnes("after_rst", 32, 32, 32, 32);
    check("after_rst_bit0", 32'(firstBits[0]), 32'd0);
    check("after_rst_bit1", 32'(firstBits[1]), 32'd1);

    // Random words with random downstream backpressure.
    for (int r = 0; r < 3; r++) begin
      rd = NCH*QUANT'($urandom);
      sendWord(rd, 1'b0);
      for (int k = 0; k < 200 && (sb.size() != 0 || oValid); k++) begin
        iReady = 1'($urandom_range(0, 1));
        @(posedge iClk);
        #1;
      end
      iReady = 1'b1;
      waitIdle();
      for (int c = 0; c < int'(NCH); c++)
        check("rand_ones", 32'(lastOnes[c]), 32'(modelQuota(rd[c*QUANT +: QUANT])));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
